ysyx_22040088_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_22040088_mem_arbiter
// PURPOSE
//  Shares the single core memory port between the ICache refill port and the DCache refill and write-back ports.
//  Breaks each cache-line request into LINE_BEATS 64-bit single-beat memory transactions, then steers each beat's ack and data back to the owner.
//  Sits between the IFU/LSU caches and the memory model (DPI/AXI bridge).
// PARAMETERS
//  LINE_BEATS  1   64-bit beats per cache line; power of two, range 1..8 (1 = 8-byte line, matching the ICache offset[2:0])
//  ADDR_W      64  address width
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous reset, active high
//  ic_rd_req     in   1   ICache line-refill request; held high until ic_ret_last
//  ic_rd_addr    in   64  ICache refill address (any byte in the line)
//  ic_ret_valid  out  1   refill beat valid to ICache
//  ic_ret_last   out  1   final beat of the ICache refill
//  ic_ret_data   out  64  refill beat data
//  dc_rd_req     in   1   DCache refill request; held high until dc_ret_last
//  dc_rd_addr    in   64  DCache refill address
//  dc_ret_valid  out  1   refill beat valid to DCache
//  dc_ret_last   out  1   final beat of the DCache refill
//  dc_ret_data   out  64  refill beat data
//  dc_wr_req     in   1   DCache write-back request; held high until dc_wr_done
//  dc_wr_addr    in   64  write-back line address
//  dc_wr_beat    out  3   index of the beat whose data the DCache must present
//  dc_wr_data    in   64  write data for beat dc_wr_beat
//  dc_wr_strb    in   8   byte strobes for beat dc_wr_beat
//  dc_wr_done    out  1   one-cycle pulse when the last write beat is acked
//  mem_valid     out  1   memory request valid
//  mem_ready     in   1   memory accepts the request this cycle
//  mem_we        out  1   1 = write, 0 = read
//  mem_addr      out  64  beat address, 8-byte aligned
//  mem_wdata     out  64  write data (pass-through of dc_wr_data)
//  mem_wstrb     out  8   write strobes; forced to 0 for reads
//  mem_ack       in   1   beat complete (read data valid, or write committed)
//  mem_rdata     in   64  read data, qualified by mem_ack
// BEHAVIOUR
//  - FSM states: IDLE -> REQ -> WAIT -> (REQ for the next beat | DONE) -> IDLE.
//  - IDLE: sample the requests and pick an owner. The owner, the line base and beat=0 are latched on the transition to REQ.
//  - Priority: dc_wr_req first, so a dirty victim is written back before its refill. If no write-back is pending, ic_rd_req and dc_rd_req are arbitrated round-robin.
//  - The round-robin pointer flips only when a read line completes. After reset the pointer favours the ICache.
//  - Line base = addr & ~(LINE_BEATS*8-1). Beat address = base + beat*8. The beat counter is log2(LINE_BEATS) bits wide and only wraps at the end of a line.
//  - REQ: mem_valid=1 with a stable address, we, wdata and wstrb until mem_ready. Go to WAIT in the cycle after the mem_ready handshake.
//  - WAIT: mem_valid=0. On mem_ack, a read pulses <owner>_ret_valid with ret_data=mem_rdata in the same cycle (combinational steer). ret_last=1 on beat LINE_BEATS-1.
//  - WAIT, write ack: on the last beat, pulse dc_wr_done. Otherwise beat++ and return to REQ.
//  - A mem_ack arriving in the same cycle as mem_ready is legal only in WAIT; mem_ack outside WAIT is ignored.
//  - DONE: one idle cycle, so no grant happens in the same cycle as the completion. This lets the requester drop its req.
//  - Latency (ready and ack both held at 1): first ret_valid 2 cycles after the req is sampled, then 2 cycles per beat after that.
//  - The non-owner's ret_valid, ret_last and wr_done stay 0. Requests that arrive mid-line wait and are not lost, because requesters hold their req.
//  - A requester dropping its req mid-line is a protocol violation; the arbiter completes the line anyway.
//  - Reset: state=IDLE, beat=0, rr=ICache, mem_valid=0, mem_we=0, mem_addr=0, mem_wstrb=0.
//  - Reset, cont.: all ret_valid, ret_last and wr_done=0, dc_wr_beat=0.
//  - Reset mid-transaction abandons the line. A late mem_ack after reset is ignored, because the state is IDLE.
// STRUCTURE
//  - Shared package ysyx_22040088_mem_pkg: FSM state encoding (IDLE/REQ/WAIT/DONE), owner IDs (OWN_IC, OWN_DC_RD, OWN_DC_WR), BEAT_BYTES=8.
//  - One sub-module, ysyx_22040088_rr_arb2: 2-way round-robin grant with a priority-override input. It is used for the IC/DC read choice.
//  - The main module holds the FSM, the beat counter, the address/owner latches and the return steering. Target size: 150-250 lines.
// TESTING
//  - Single IC refill, LINE_BEATS=1, ic_rd_addr=0x8000_0004, ready/ack=1:
//    mem_addr=0x8000_0000, we=0. ic_ret_valid+last at cycle 2 with data=mem_rdata. No dc_* outputs toggle.
//  - Simultaneous ic_rd_req and dc_rd_req after reset: the IC is served first, then the DC.
//    Repeat with both held: grants alternate IC, DC, IC, DC.
//  - dc_wr_req and dc_rd_req together, with ic_rd_req also pending, LINE_BEATS=4, wr addr 0x8000_1038:
//    the write goes first with 4 beats at 0x8000_1020/28/30/38, dc_wr_beat=0..3 and one dc_wr_done pulse. Then the DC or IC read per the rr pointer.
//  - Back-pressure: hold mem_ready=0 for 5 cycles, then delay mem_ack by 3 cycles.
//    Address, we and strb stay stable during REQ, and mem_valid drops after the handshake. No spurious ret_valid appears.
//  - Reset asserted in WAIT of beat 2 of 4, with mem_ack arriving the next cycle: all outputs go to reset values and the ack is ignored.
//    A new ic_rd_req is then served from beat 0.

Source files
------------

// File: rtl/ysyx_22040088_mem_pkg.sv
// Shared definitions for the cache-to-memory arbiter: FSM states, owner IDs
// and the fixed 64-bit beat size.
package ysyx_22040088_mem_pkg;

  localparam int BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_IC,
    OWN_DC_RD,
    OWN_DC_WR
  } owner_t;

  // A one-beat line still needs a 1-bit counter so the vectors stay legal.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ysyx_22040088_rr_arb2.sv
// Two-way round-robin grant. When block is high nothing is granted, which lets
// a higher-priority requester outside this arbiter take the port.
module ysyx_22040088_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       block,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr=0 favours req[0] on a tie; it flips once per completed transaction.
  logic ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (!block) begin
      if (req == 2'b11) begin
        gnt = ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/ysyx_22040088_mem_arbiter.sv
// Shares the single core memory port between ICache refill, DCache refill and
// DCache write-back, splitting each line into 64-bit single-beat transactions.
module ysyx_22040088_mem_arbiter
  import ysyx_22040088_mem_pkg::*;
#(
  parameter int LINE_BEATS = 1,
  parameter int ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ic_rd_req,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [63:0]       ic_ret_data,

  input  logic              dc_rd_req,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [63:0]       dc_ret_data,

  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  output logic [2:0]        dc_wr_beat,
  input  logic [63:0]       dc_wr_data,
  input  logic [7:0]        dc_wr_strb,
  output logic              dc_wr_done,

  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata
);

  localparam int                BEAT_W      = beat_width(LINE_BEATS);
  localparam int                LINE_BYTES  = LINE_BEATS * BEAT_BYTES;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_BYTES - 1);

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a & ~OFFSET_MASK;
  endfunction

  function automatic logic [ADDR_W-1:0] beat_offset(input logic [BEAT_W-1:0] b);
    return ADDR_W'({b, 3'b000});
  endfunction

  state_t            state;
  owner_t            owner;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_next;
  logic [ADDR_W-1:0] base;

  logic              beat_ack;
  logic              last_ack;
  logic              is_write;
  logic [1:0]        rd_gnt;

  logic              grant_valid;
  owner_t            grant_owner;
  logic [ADDR_W-1:0] grant_addr;

  assign beat_next = beat + BEAT_W'(1);
  assign is_write  = (owner == OWN_DC_WR);
  assign beat_ack  = (state == WAIT) && mem_ack;
  assign last_ack  = beat_ack && (beat == LAST_BEAT);

  // Write-back blocks the read arbiter so a dirty victim leaves before its refill.
  ysyx_22040088_rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({dc_rd_req, ic_rd_req}),
    .block   (dc_wr_req),
    .advance (last_ack && !is_write),
    .gnt     (rd_gnt)
  );

  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_IC;
    grant_addr  = ic_rd_addr;
    if (dc_wr_req) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DC_WR;
      grant_addr  = dc_wr_addr;
    end else if (rd_gnt[0]) begin
      grant_valid = 1'b1;
      grant_owner = OWN_IC;
      grant_addr  = ic_rd_addr;
    end else if (rd_gnt[1]) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DC_RD;
      grant_addr  = dc_rd_addr;
    end
  end

  // DONE is a dead cycle so a requester can drop its req before the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IC;
      beat      <= '0;
      base      <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_owner;
            base      <= line_base(grant_addr);
            beat      <= '0;
            mem_addr  <= line_base(grant_addr);
            mem_we    <= (grant_owner == OWN_DC_WR);
            mem_valid <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            if (beat == LAST_BEAT) begin
              state <= DONE;
            end else begin
              beat      <= beat_next;
              mem_addr  <= base + beat_offset(beat_next);
              mem_valid <= 1'b1;
              state     <= REQ;
            end
          end
        end
        DONE: begin
          beat   <= '0;
          mem_we <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_wdata = dc_wr_data;
  assign mem_wstrb = ((state == REQ) && mem_we) ? dc_wr_strb : 8'h00;

  assign dc_wr_beat = 3'(beat);
  assign dc_wr_done = last_ack && is_write;

  // Read data is steered combinationally in the ack cycle to the line owner.
  assign ic_ret_valid = beat_ack && (owner == OWN_IC);
  assign ic_ret_last  = ic_ret_valid && (beat == LAST_BEAT);
  assign ic_ret_data  = mem_rdata;

  assign dc_ret_valid = beat_ack && (owner == OWN_DC_RD);
  assign dc_ret_last  = dc_ret_valid && (beat == LAST_BEAT);
  assign dc_ret_data  = mem_rdata;

endmodule

// File: tb/tb_ysyx_22040088_mem_arbiter.sv
// Self-checking bench: a 1-beat instance for the latency case and a 4-beat
// instance driven against a memory model with a scoreboard of expected beats.
module tb_ysyx_22040088_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 4-beat instance
  logic        ic_rd_req, dc_rd_req, dc_wr_req;
  logic [63:0] ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic        ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last, dc_wr_done;
  logic [63:0] ic_ret_data, dc_ret_data, dc_wr_data;
  logic [2:0]  dc_wr_beat;
  logic [7:0]  dc_wr_strb;
  logic        mem_valid, mem_ready, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;

  // 1-beat instance, memory always ready and acking
  logic        s_ic_rd_req;
  logic [63:0] s_ic_rd_addr;
  logic        s_ic_ret_valid, s_ic_ret_last, s_dc_ret_valid, s_dc_ret_last, s_dc_wr_done;
  logic [63:0] s_ic_ret_data, s_dc_ret_data;
  logic [2:0]  s_dc_wr_beat;
  logic        s_mem_valid, s_mem_we;
  logic [63:0] s_mem_addr, s_mem_wdata;
  logic [7:0]  s_mem_wstrb;
  logic [63:0] s_rdata = 64'hDEAD_BEEF_0123_4567;

  int vectors = 0;
  int miscompares = 0;
  int hs_count = 0;
  int lines_done = 0;
  int ack_delay = 0;
  logic ignore_ack = 1'b0;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [2:0]  beat;
    int          who;
    logic        last;
  } beat_t;

  beat_t exp_req[$];
  beat_t exp_cpl[$];

  function automatic logic [63:0] rd_data_of(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  function automatic logic [63:0] wr_data_of(input logic [2:0] b);
    return 64'hC0DE_0000_0000_0000 + {61'd0, b} * 64'h0000_0101_0101_0101;
  endfunction

  function automatic logic [7:0] wr_strb_of(input logic [2:0] b);
    return 8'hF0 ^ {5'd0, b};
  endfunction

  assign dc_wr_data = wr_data_of(dc_wr_beat);
  assign dc_wr_strb = wr_strb_of(dc_wr_beat);

  ysyx_22040088_mem_arbiter #(.LINE_BEATS(4), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_beat(dc_wr_beat),
    .dc_wr_data(dc_wr_data), .dc_wr_strb(dc_wr_strb), .dc_wr_done(dc_wr_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  ysyx_22040088_mem_arbiter #(.LINE_BEATS(1), .ADDR_W(64)) dut_s (
    .clk(clk), .rst(rst),
    .ic_rd_req(s_ic_rd_req), .ic_rd_addr(s_ic_rd_addr),
    .ic_ret_valid(s_ic_ret_valid), .ic_ret_last(s_ic_ret_last), .ic_ret_data(s_ic_ret_data),
    .dc_rd_req(1'b0), .dc_rd_addr(64'd0),
    .dc_ret_valid(s_dc_ret_valid), .dc_ret_last(s_dc_ret_last), .dc_ret_data(s_dc_ret_data),
    .dc_wr_req(1'b0), .dc_wr_addr(64'd0), .dc_wr_beat(s_dc_wr_beat),
    .dc_wr_data(64'd0), .dc_wr_strb(8'd0), .dc_wr_done(s_dc_wr_done),
    .mem_valid(s_mem_valid), .mem_ready(1'b1), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_wstrb(s_mem_wstrb), .mem_ack(1'b1), .mem_rdata(s_rdata)
  );

  // Memory model: accepts one beat, acks it ack_delay cycles after WAIT starts.
  logic        pend = 1'b0;
  logic [63:0] pend_addr = 64'd0;
  int          ack_cnt = 0;

  always @(posedge clk) begin
    if (pend && ack_cnt == 0) begin
      pend <= 1'b0;
    end else if (pend) begin
      ack_cnt <= ack_cnt - 1;
    end
    if (mem_valid && mem_ready) begin
      pend      <= 1'b1;
      pend_addr <= mem_addr;
      ack_cnt   <= ack_delay;
    end
  end

  assign mem_ack   = pend && (ack_cnt == 0);
  assign mem_rdata = rd_data_of(pend_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input int who, input logic [63:0] addr);
    beat_t e;
    for (int b = 0; b < 4; b++) begin
      e.addr = (addr & ~64'h1F) + 64'(b * 8);
      e.we   = (who == 2);
      e.beat = 3'(b);
      e.who  = who;
      e.last = (b == 3);
      exp_req.push_back(e);
      exp_cpl.push_back(e);
    end
  endtask

  task automatic wait_lines(input int target, input string tag);
    for (int i = 0; i < 400 && lines_done < target; i++) begin
      @(negedge clk);
      #1;
    end
    check(tag, 64'(lines_done), 64'(target));
    @(posedge clk);
    #2;
  endtask

  // Monitor: every handshake and every ack is matched against the scoreboard.
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [63:0] prev_addr = 64'd0;
  logic        prev_we = 1'b0;
  logic [7:0]  prev_strb = 8'd0;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_hs) check("valid_drop", 64'(mem_valid), 64'd0);
      if (prev_valid && !prev_hs && mem_valid) begin
        check("stable_addr", mem_addr, prev_addr);
        check("stable_we", 64'(mem_we), 64'(prev_we));
        check("stable_strb", 64'(mem_wstrb), 64'(prev_strb));
      end
      if (mem_valid && mem_ready) begin
        hs_count++;
        vectors++;
        assert (exp_req.size() > 0) else begin
          miscompares++;
          $error("[TB] FAIL req_queue observed=empty required=pending addr=%h", mem_addr);
        end
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front();
          check("req_addr", mem_addr, e.addr);
          check("req_we", 64'(mem_we), 64'(e.we));
          check("req_strb", 64'(mem_wstrb), e.we ? 64'(wr_strb_of(e.beat)) : 64'd0);
          if (e.we) begin
            check("wr_beat", 64'(dc_wr_beat), 64'(e.beat));
            check("wr_data", mem_wdata, wr_data_of(e.beat));
          end
        end
      end
      if (mem_ack && !ignore_ack && exp_cpl.size() > 0) begin
        e = exp_cpl.pop_front();
        check("ic_ret_valid", 64'(ic_ret_valid), 64'(e.who == 0));
        check("dc_ret_valid", 64'(dc_ret_valid), 64'(e.who == 1));
        check("ic_ret_last", 64'(ic_ret_last), 64'(e.who == 0 && e.last));
        check("dc_ret_last", 64'(dc_ret_last), 64'(e.who == 1 && e.last));
        check("wr_done", 64'(dc_wr_done), 64'(e.who == 2 && e.last));
        if (e.who == 0) check("ic_ret_data", ic_ret_data, rd_data_of(e.addr));
        if (e.who == 1) check("dc_ret_data", dc_ret_data, rd_data_of(e.addr));
        if (e.last) lines_done++;
      end else begin
        check("ret_quiet", 64'({ic_ret_valid, dc_ret_valid, ic_ret_last, dc_ret_last, dc_wr_done}), 64'd0);
      end
      prev_valid = mem_valid;
      prev_hs    = mem_valid && mem_ready;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_strb  = mem_wstrb;
    end
  end

  initial begin
    int target;
    rst = 1'b1;
    ic_rd_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
    ic_rd_addr = 64'd0; dc_rd_addr = 64'd0; dc_wr_addr = 64'd0;
    s_ic_rd_req = 1'b0; s_ic_rd_addr = 64'd0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_wr_beat", 64'(dc_wr_beat), 64'd0);
    check("rst_s_mem_valid", 64'(s_mem_valid), 64'd0);
    check("rst_s_ret", 64'({s_ic_ret_valid, s_ic_ret_last, s_dc_ret_valid, s_dc_wr_done}), 64'd0);
    rst = 1'b0;

    $display("[TB] single-beat ICache refill latency");
    s_ic_rd_req = 1'b1;
    s_ic_rd_addr = 64'h8000_0004;
    @(posedge clk); #2;
    check("s_req_valid", 64'(s_mem_valid), 64'd1);
    check("s_req_addr", s_mem_addr, 64'h8000_0000);
    check("s_req_we", 64'(s_mem_we), 64'd0);
    check("s_early_ret", 64'(s_ic_ret_valid), 64'd0);
    @(posedge clk); #2;
    check("s_ret_valid", 64'(s_ic_ret_valid), 64'd1);
    check("s_ret_last", 64'(s_ic_ret_last), 64'd1);
    check("s_ret_data", s_ic_ret_data, 64'hDEAD_BEEF_0123_4567);
    check("s_dc_quiet", 64'({s_dc_ret_valid, s_dc_ret_last, s_dc_wr_done}), 64'd0);
    @(posedge clk); #2;
    s_ic_rd_req = 1'b0;
    check("s_done_ret", 64'(s_ic_ret_valid), 64'd0);
    check("s_done_valid", 64'(s_mem_valid), 64'd0);

    $display("[TB] simultaneous reads alternate IC/DC");
    push_line(0, 64'h8000_2008);
    push_line(1, 64'h8000_3010);
    push_line(0, 64'h8000_2008);
    push_line(1, 64'h8000_3010);
    ic_rd_addr = 64'h8000_2008;
    dc_rd_addr = 64'h8000_3010;
    ic_rd_req = 1'b1;
    dc_rd_req = 1'b1;
    wait_lines(lines_done + 4, "rr_lines");
    ic_rd_req = 1'b0;
    dc_rd_req = 1'b0;

    $display("[TB] write-back first, then reads");
    push_line(2, 64'h8000_1038);
    push_line(0, 64'h8000_4000);
    push_line(1, 64'h8000_5000);
    dc_wr_addr = 64'h8000_1038;
    ic_rd_addr = 64'h8000_4000;
    dc_rd_addr = 64'h8000_5000;
    dc_wr_req = 1'b1;
    ic_rd_req = 1'b1;
    dc_rd_req = 1'b1;
    wait_lines(lines_done + 1, "wb_line");
    dc_wr_req = 1'b0;
    wait_lines(lines_done + 1, "ic_after_wb");
    ic_rd_req = 1'b0;
    wait_lines(lines_done + 1, "dc_after_wb");
    dc_rd_req = 1'b0;

    $display("[TB] back-pressure on ready and ack");
    mem_ready = 1'b0;
    ack_delay = 3;
    push_line(0, 64'h8000_6018);
    ic_rd_addr = 64'h8000_6018;
    ic_rd_req = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    mem_ready = 1'b1;
    wait_lines(lines_done + 1, "bp_line");
    ic_rd_req = 1'b0;

    $display("[TB] reset in WAIT of beat 2");
    ack_delay = 1;
    push_line(0, 64'h8000_7000);
    ic_rd_addr = 64'h8000_7000;
    ic_rd_req = 1'b1;
    target = hs_count + 3;
    for (int i = 0; i < 200 && hs_count < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("hs_wait", 64'(hs_count), 64'(target));
    @(posedge clk); #2;
    rst = 1'b1;
    ignore_ack = 1'b1;
    ic_rd_req = 1'b0;
    @(posedge clk); #2;
    check("mid_rst_valid", 64'(mem_valid), 64'd0);
    check("mid_rst_addr", mem_addr, 64'd0);
    check("mid_rst_we", 64'(mem_we), 64'd0);
    check("mid_rst_beat", 64'(dc_wr_beat), 64'd0);
    check("mid_rst_ret", 64'({ic_ret_valid, ic_ret_last, dc_ret_valid, dc_wr_done}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #2;
    ignore_ack = 1'b0;
    exp_req.delete();
    exp_cpl.delete();
    ack_delay = 0;
    push_line(0, 64'h8000_8000);
    ic_rd_addr = 64'h8000_8000;
    ic_rd_req = 1'b1;
    wait_lines(lines_done + 1, "post_rst_line");
    ic_rd_req = 1'b0;
    repeat (3) @(posedge clk);
    check("req_queue_drained", 64'(exp_req.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
